div_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, which id decodes under funct7=0000001 and funct3[2]=1.
//  ex raises start_i with operands and the destination register; the block runs a radix-2 restoring divider.
//  It raises hold_o to stall the front end, then writes the result back with a one-cycle ready_o/reg_we_o pulse.

---
 rtl/div_sequencer.sv | 99 +++++++++
 tb/tb_div_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (DIV_EARLY_OUT_EN enables START-state early out)
module div_sequencer #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [DATA_W-1:0]  dividend_i,
  input  logic [DATA_W-1:0]  divisor_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               flush_i,
  output logic               hold_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic [DATA_W-1:0]  result_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;
  state_t             state;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q, dvd, rem, quot, result_q;
  logic [RADDR_W-1:0] rd_q, waddr_q;
  logic [CW-1:0]      cnt;
  logic               sa, sb, ge, early;
  logic [DATA_W-1:0]  abs_a, abs_b, fin;
  logic [DATA_W:0]    trial;
  // magnitudes, trial subtraction, and the sign-corrected / divide-by-zero final result
  always_comb begin
    sa = !op_q[0] && a_q[DATA_W-1];
    sb = !op_q[0] && b_q[DATA_W-1];
    abs_a = sa ? -a_q : a_q;
    abs_b = sb ? -b_q : b_q;
    trial = {rem, dvd[DATA_W-1]} - {1'b0, abs_b};
    ge = !trial[DATA_W];
    fin = (b_q == '0) ? (op_q[1] ? a_q : '1) : op_q[1] ? (sa ? -rem : rem) : ((sa ^ sb) ? -quot : quot);
`ifdef DIV_EARLY_OUT_EN
    early = (b_q == '0) || (abs_a < abs_b);
`else
    early = 1'b0;
`endif
  end
  assign busy_o      = state != S_IDLE;
  assign ready_o     = state == S_END && !flush_i;
  assign reg_we_o    = ready_o;
  assign result_o    = state == S_END ? fin : result_q;
  assign reg_waddr_o = state == S_END ? rd_q : waddr_q;
  assign hold_o      = !rst && (state == S_IDLE ? start_i && !flush_i : state != S_END);
  // sequencer: accept, form magnitudes, iterate, then commit the result on END unless flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      dvd      <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      result_q <= '0;
      waddr_q  <= '0;
    end else if (state != S_IDLE && flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_i && !flush_i) begin
          op_q  <= op_i[1:0];
          a_q   <= dividend_i;
          b_q   <= divisor_i;
          rd_q  <= reg_waddr_i;
          state <= S_START;
        end
        S_START: begin
          dvd   <= abs_a;
          rem   <= early ? abs_a : '0;
          quot  <= '0;
          cnt   <= CW'(DATA_W - 1);
          state <= early ? S_END : S_CALC;
        end
        S_CALC: begin
          rem   <= ge ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
          dvd   <= dvd << 1;
          quot  <= {quot[DATA_W-2:0], ge};
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? S_END : S_CALC;
        end
        default: begin
          result_q <= fin;
          waddr_q  <= rd_q;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed RV32M divide tests against an arithmetic reference model
module tb_div_sequencer;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
  localparam int EL = 2;
`else
  localparam bit EARLY = 1'b0;
  localparam int EL = 34;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        start_i = 1'b0, flush_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] dividend_i = '0, divisor_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        hold_o, busy_o, ready_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;
  int checks = 0, errors = 0;

  div_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i), .hold_o(hold_o),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mag(input logic [2:0] op, input logic [31:0] x);
    return (!op[0] && x[31]) ? -x : x;
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (op == 3'b100) return (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : $unsigned($signed(a) / $signed(b));
    if (op == 3'b110) return (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : $unsigned($signed(a) % $signed(b));
    if (op == 3'b101) return a / b;
    return a % b;
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (EARLY && (b == 0 || mag(op, a) < mag(op, b))) ? 2 : 34;
  endfunction

  // reference model: k = cycles since accept (0 = idle), END reached when k == m_lat
  int          k = 0, m_lat = 0;
  logic [31:0] m_res = '0, m_out = '0;
  logic [4:0]  m_rd = '0, m_wa = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      m_out <= '0;
      m_wa <= '0;
    end else if (k == 0) begin
      if (start_i && !flush_i) begin
        k <= 1;
        m_res <= ref_div(op_i, dividend_i, divisor_i);
        m_lat <= lat_of(op_i, dividend_i, divisor_i);
        m_rd <= reg_waddr_i;
      end
    end else if (flush_i) k <= 0;
    else if (k == m_lat) begin
      k <= 0;
      m_out <= m_res;
      m_wa <= m_rd;
    end else k <= k + 1;
  end

  logic exp_ready, exp_hold;
  always @(negedge clk) begin
    exp_ready = k != 0 && k == m_lat && !flush_i;
    exp_hold = k == 0 ? (!rst && start_i && !flush_i) : (k != m_lat);
    chk("busy_o", 32'(busy_o), 32'(k != 0));
    chk("hold_o", 32'(hold_o), 32'(exp_hold));
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("reg_we_o", 32'(reg_we_o), 32'(exp_ready));
    if (k == 0) begin
      chk("result_held", result_o, m_out);
      chk("waddr_held", 32'(reg_waddr_o), 32'(m_wa));
    end else if (exp_ready) begin
      chk("result_model", result_o, m_res);
      chk("waddr_model", 32'(reg_waddr_o), 32'(m_rd));
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit keep);
    int n;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
    @(posedge clk); #1;
    if (!keep) start_i = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      if (n > 60) begin
        errors++;
        $display("FAIL ready_timeout got none expected ready within 60 cycles");
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("result", result_o, exp);
    chk("waddr", 32'(reg_waddr_o), 32'(rd));
    #1 start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_result", result_o, 0);
    #1;
    do_op(3'b101, 100, 7, 5'd3, 14, 34, 1'b0);
    do_op(3'b111, 100, 7, 5'd4, 2, 34, 1'b0);
    do_op(3'b100, 32'hFFFFFFF9, 2, 5'd5, 32'hFFFFFFFD, 34, 1'b0);
    do_op(3'b110, 32'hFFFFFFF9, 2, 5'd6, 32'hFFFFFFFF, 34, 1'b0);
    do_op(3'b110, 7, 32'hFFFFFFFE, 5'd7, 1, 34, 1'b0);
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 34, 1'b0);
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd9, 0, 34, 1'b0);
    do_op(3'b100, 5, 0, 5'd10, 32'hFFFFFFFF, EL, 1'b0);
    do_op(3'b111, 5, 0, 5'd11, 5, EL, 1'b0);
    do_op(3'b101, 3, 9, 5'd12, 0, EL, 1'b0);
    do_op(3'b111, 3, 9, 5'd13, 3, EL, 1'b1);
    @(negedge clk);
    chk("no_second_accept", 32'(busy_o), 0);
    #1;
    do_op(3'b100, 32'hFFFFFF9C, 7, 5'd14, 32'hFFFFFFF2, 34, 1'b0);
    // flush mid-CALC at T+10, new accept at T+11
    start_i = 1'b1; op_i = 3'b101; dividend_i = 1000; divisor_i = 3; reg_waddr_i = 5'd15;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy_o), 0);
    chk("flush_hold", 32'(hold_o), 0);
    chk("flush_result_kept", result_o, 32'hFFFFFFF2);
    #1;
    do_op(3'b101, 200, 10, 5'd16, 20, 34, 1'b0);
    // flush during END suppresses the write-back
    start_i = 1'b1; op_i = 3'b101; dividend_i = 100; divisor_i = 7; reg_waddr_i = 5'd17;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (33) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk("end_flush_ready", 32'(ready_o), 0);
    chk("end_flush_we", 32'(reg_we_o), 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("end_flush_result", result_o, 20);
    chk("end_flush_waddr", 32'(reg_waddr_o), 16);
    #1;
    // asynchronous reset mid-CALC
    start_i = 1'b1; op_i = 3'b111; dividend_i = 12345; divisor_i = 10; reg_waddr_i = 5'd18;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_hold", 32'(hold_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_we", 32'(reg_we_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_waddr", 32'(reg_waddr_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    do_op(3'b111, 12345, 10, 5'd19, 5, 34, 1'b0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
